scheduler_tx_arbiter: RTL

SCHEDULER_TX_ARBITER -- requirements
Module: scheduler_tx_arbiter

---
 rtl/scheduler_tx_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/scheduler_tx_arbiter.sv
// Packet-granular round-robin arbiter that merges the scheduler TX stream
// (input 0) and the host TX stream (input 1) onto one registered AXI-Stream
// output toward the MAC, and counts forwarded packets per input.
module scheduler_tx_arbiter #(
   parameter int AXIS_DATA_WIDTH = 64,
   parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8
) (
   input  logic                       clk,
   input  logic                       rst,

   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_sched_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_sched_tkeep,
   input  logic                       s_axis_sched_tvalid,
   output logic                       s_axis_sched_tready,
   input  logic                       s_axis_sched_tlast,

   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_host_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_host_tkeep,
   input  logic                       s_axis_host_tvalid,
   output logic                       s_axis_host_tready,
   input  logic                       s_axis_host_tlast,

   output logic [AXIS_DATA_WIDTH-1:0] m_axis_tx_tdata,
   output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tx_tkeep,
   output logic                       m_axis_tx_tvalid,
   input  logic                       m_axis_tx_tready,
   output logic                       m_axis_tx_tlast,

   input  logic                       w_rst_pkt_counter,
   output logic [31:0]                w_sched_pkt_counter,
   output logic [31:0]                w_host_pkt_counter
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      GRANT_SCHED = 2'd1,
      GRANT_HOST  = 2'd2
   } state_t;

   localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

   state_t                     state;
   state_t                     state_next;
   logic                       last_grant_host;  // 1: host won the most recent arbitration
   logic                       out_free;
   logic                       sched_accept;
   logic                       host_accept;
   logic                       beat_accept;
   logic [AXIS_DATA_WIDTH-1:0] beat_data;
   logic [AXIS_KEEP_WIDTH-1:0] beat_keep;
   logic                       beat_last;

   // The output register can take a beat when empty or emptying this cycle.
   assign out_free = !m_axis_tx_tvalid || m_axis_tx_tready;

   // Only the owner of the current packet sees tready, and never during reset.
   assign s_axis_sched_tready = rst && (state == GRANT_SCHED) && out_free;
   assign s_axis_host_tready  = rst && (state == GRANT_HOST)  && out_free;

   assign sched_accept = s_axis_sched_tvalid && s_axis_sched_tready;
   assign host_accept  = s_axis_host_tvalid  && s_axis_host_tready;
   assign beat_accept  = sched_accept || host_accept;

   assign beat_data = (state == GRANT_HOST) ? s_axis_host_tdata : s_axis_sched_tdata;
   assign beat_keep = (state == GRANT_HOST) ? s_axis_host_tkeep : s_axis_sched_tkeep;
   assign beat_last = (state == GRANT_HOST) ? s_axis_host_tlast : s_axis_sched_tlast;

   // Next state: choose a packet owner in IDLE, release it on its tlast beat.
   always_comb begin
      // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
      state_next = state;
      case (state)
         IDLE: begin
            if (s_axis_sched_tvalid && s_axis_host_tvalid) begin
               state_next = last_grant_host ? GRANT_SCHED : GRANT_HOST;
            end else if (s_axis_sched_tvalid) begin
               state_next = GRANT_SCHED;
            end else if (s_axis_host_tvalid) begin
               state_next = GRANT_HOST;
            end
         end
         GRANT_SCHED: begin
            if (sched_accept && s_axis_sched_tlast) state_next = IDLE;
         end
         GRANT_HOST: begin
            if (host_accept && s_axis_host_tlast) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register and round-robin memory, updated on entry to a grant state.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous -- it is only looked at inside the clocked block.
      if (!rst) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         state           <= IDLE;
         last_grant_host <= 1'b1;
      end else begin
         state <= state_next;
         if (state == IDLE && state_next == GRANT_SCHED) begin
            last_grant_host <= 1'b0;
         end else if (state == IDLE && state_next == GRANT_HOST) begin
            last_grant_host <= 1'b1;
         end
      end
   end

   // Output stage: load an accepted beat, drop tvalid once the sink takes it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         m_axis_tx_tdata  <= '0;
         m_axis_tx_tkeep  <= '0;
         m_axis_tx_tlast  <= 1'b0;
         m_axis_tx_tvalid <= 1'b0;
      end else if (beat_accept) begin
         m_axis_tx_tdata  <= beat_data;
         m_axis_tx_tkeep  <= beat_keep;
         m_axis_tx_tlast  <= beat_last;
         m_axis_tx_tvalid <= 1'b1;
      end else if (m_axis_tx_tready) begin
         m_axis_tx_tvalid <= 1'b0;
      end
   end

   // Saturating per-input packet counters; the clear wins over an increment.
   always_ff @(posedge clk) begin
      if (!rst || w_rst_pkt_counter) begin
         w_sched_pkt_counter <= '0;
         w_host_pkt_counter  <= '0;
      end else begin
         if (sched_accept && s_axis_sched_tlast && w_sched_pkt_counter != COUNT_MAX) begin
            w_sched_pkt_counter <= w_sched_pkt_counter + 32'd1;
         end
         if (host_accept && s_axis_host_tlast && w_host_pkt_counter != COUNT_MAX) begin
            w_host_pkt_counter <= w_host_pkt_counter + 32'd1;
         end
      end
   end

endmodule
